// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester arbiter.
//   N_REQ / CODE_W : requester count and encoded-owner width
//   state_t        : arbiter sequencing states
//   code_to_onehot : converts an owner code into a grant vector in which
//                    index 0 (the leftmost bit) corresponds to req[0]
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  function automatic logic [0:N_REQ-1] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [0:N_REQ-1] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational 4-to-2 priority encoder with a rotating start point.
// The search begins at index 'start' and wraps 3 -> 0; the first asserted
// request found wins. With start = 0 this is a plain fixed-priority encoder
// in which req[0] is the highest priority and encodes to 2'b00.
// Ports:
//   req   in  [0:3]  request vector
//   start in  [1:0]  index at which the search begins
//   code  out [1:0]  absolute index of the winner (0 when nothing is requested)
//   valid out        at least one request bit is set
module arb_prio_enc
  import arb_pkg::*;
(
  input  logic [0:N_REQ-1]  req,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] code,
  output logic              valid
);

  logic [CODE_W-1:0] idx;

  always_comb begin
    code  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // Two-bit addition wraps the search index naturally.
      idx = start + CODE_W'(i);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        code  = idx;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Sequencing arbiter sharing one downstream resource among 4 requesters.
// A registered FSM (IDLE -> GRANT -> RECOVER -> IDLE) latches the encoder's
// winner as a one-hot grant, holds it until the owner asserts done or drops
// its request, and revokes it with a one-cycle timeout_err pulse once the
// grant has been held for MAX_HOLD cycles. RECOVER inserts one idle
// turnaround cycle between owners. There is no preemption.
// Optional build macro REQ_ARBITER_RR_EN: round-robin selection with a
// priority pointer that moves to owner+1 on every release. Without it,
// req[0] always has the highest priority.
// Ports:
//   clk         in         rising-edge clock
//   rst         in         asynchronous, active-high reset
//   req         in  [0:3]  request vector
//   done        in         owner releases the resource (sampled in GRANT)
//   gnt         out [0:3]  registered one-hot grant
//   gnt_code    out [0:1]  registered owner index; qualify with busy
//   busy        out        a grant is active
//   timeout_err out        one-cycle pulse on hold-timer revocation
module req_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [0:3]     req,
  input  logic           done,
  output logic [0:3]     gnt,
  output logic [0:1]     gnt_code,
  output logic           busy,
  output logic           timeout_err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [0:N_REQ-1]   gnt_q, gnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CODE_W-1:0]  start;
  logic [CODE_W-1:0]  enc_code;
  logic               enc_valid;

`ifdef REQ_ARBITER_RR_EN
  logic [CODE_W-1:0]  ptr_q;

  // Pointer advances past the owner whenever the grant is given up,
  // whatever the cause (done, request drop or timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == GRANT && state_d == RECOVER) begin
      ptr_q <= code_q + 1'b1;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  arb_prio_enc u_enc (
    .req   (req),
    .start (start),
    .code  (enc_code),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    code_d  = code_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (enc_valid) begin
          gnt_d   = code_to_onehot(enc_code);
          code_d  = enc_code;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A voluntary release is checked first so that done on the final
        // allowed cycle suppresses the timeout pulse.
        if (done || !req[code_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = RECOVER;
        end else if (cnt_q == HOLD_LAST) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign gnt_code    = code_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Testbench for req_arbiter_4: directed stimulus with hand-computed literal
// expectations plus a cycle-level ownership model compared every cycle.
module tb_req_arbiter_4;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:3] req;
  logic       done;
  logic [0:3] gnt;
  logic [0:1] gnt_code;
  logic       busy;
  logic       timeout_err;

  int vectors = 0;
  int errors  = 0;

  req_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_code    (gnt_code),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Ownership model: who holds the resource, for how long, and whether the
  // one-cycle turnaround gap is in progress.
  int m_owner;   // -1 when nobody owns the resource
  int m_held;    // cycles owned so far, minus one
  bit m_gap;     // turnaround cycle after a release
  int m_last;    // last owner index
  bit m_terr;
`ifdef REQ_ARBITER_RR_EN
  int m_ptr;
`endif

  always @(posedge clk or posedge rst) begin
    int w;
    int base;
    int idx;
    if (rst) begin
      m_owner <= -1;
      m_held  <= 0;
      m_gap   <= 1'b0;
      m_last  <= 0;
      m_terr  <= 1'b0;
`ifdef REQ_ARBITER_RR_EN
      m_ptr   <= 0;
`endif
    end else begin
      m_terr <= 1'b0;
      if (m_owner >= 0) begin
        if (done || !req[m_owner]) begin
          m_owner <= -1;
          m_gap   <= 1'b1;
`ifdef REQ_ARBITER_RR_EN
          m_ptr   <= (m_owner + 1) % 4;
`endif
        end else if (m_held + 1 == MAX_HOLD) begin
          m_owner <= -1;
          m_gap   <= 1'b1;
          m_terr  <= 1'b1;
`ifdef REQ_ARBITER_RR_EN
          m_ptr   <= (m_owner + 1) % 4;
`endif
        end else begin
          m_held <= m_held + 1;
        end
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end else begin
`ifdef REQ_ARBITER_RR_EN
        base = m_ptr;
`else
        base = 0;
`endif
        w = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (base + k) % 4;
          if (w < 0 && req[idx]) w = idx;
        end
        if (w >= 0) begin
          m_owner <= w;
          m_last  <= w;
          m_held  <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [0:3] exp_gnt;
    if (!rst) begin
      exp_gnt = '0;
      if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
      check("model_gnt", 32'(gnt), 32'(exp_gnt));
      check("model_busy", 32'(busy), 32'(m_owner >= 0));
      check("model_gnt_code", 32'(gnt_code), 32'(m_last));
      check("model_timeout_err", 32'(timeout_err), 32'(m_terr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick(2);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_gnt_code", 32'(gnt_code), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_timeout_err", 32'(timeout_err), 32'h0);
    rst = 1'b0;

    // Priority: req[1] beats req[2]
    req = 4'b0110;
    tick(1);
    check("prio_gnt", 32'(gnt), 32'(4'b0100));
    check("prio_code", 32'(gnt_code), 32'(2'b01));
    check("prio_busy", 32'(busy), 32'h1);
    done = 1'b1;
    tick(1);
    check("done_recover_gnt", 32'(gnt), 32'h0);
    check("done_recover_busy", 32'(busy), 32'h0);
    done = 1'b0;
    req  = 4'b0010;
    tick(1);
    check("idle_gap_gnt", 32'(gnt), 32'h0);
    tick(1);
    check("second_gnt", 32'(gnt), 32'(4'b0010));
    check("second_code", 32'(gnt_code), 32'(2'b10));

    // Owner drops its request; then the lowest-priority requester alone
    req = 4'b0001;
    tick(1);
    check("drop_gnt", 32'(gnt), 32'h0);
    tick(2);
    check("low_gnt", 32'(gnt), 32'(4'b0001));
    check("low_code", 32'(gnt_code), 32'(2'b11));
    req = 4'b0000;
    tick(1);
    check("low_drop_gnt", 32'(gnt), 32'h0);
    check("low_drop_terr", 32'(timeout_err), 32'h0);
    tick(2);

    // Hold timer
    req = 4'b1000;
    tick(1);
    n = 0;
    while (gnt == 4'b1000 && n < 40) begin
      n++;
      tick(1);
    end
    check("hold_cycles", 32'(n), 32'(MAX_HOLD));
    check("timeout_pulse", 32'(timeout_err), 32'h1);
    check("timeout_gnt", 32'(gnt), 32'h0);
    tick(1);
    check("timeout_pulse_end", 32'(timeout_err), 32'h0);
    check("timeout_idle_gnt", 32'(gnt), 32'h0);
    tick(1);
    check("regrant_gnt", 32'(gnt), 32'(4'b1000));

    // done on the final allowed cycle wins over the timer
    tick(MAX_HOLD - 1);
    check("collide_pre_gnt", 32'(gnt), 32'(4'b1000));
    done = 1'b1;
    tick(1);
    check("collide_gnt", 32'(gnt), 32'h0);
    check("collide_terr", 32'(timeout_err), 32'h0);
    done = 1'b0;
    req  = 4'b0000;
    tick(1);
    check("collide_after_terr", 32'(timeout_err), 32'h0);

    // Asynchronous reset in the middle of a grant
    req = 4'b0010;
    n = 0;
    while (gnt != 4'b0010 && n < 10) begin
      n++;
      tick(1);
    end
    check("rst_pre_gnt", 32'(gnt), 32'(4'b0010));
    #1 rst = 1'b1;
    #1;
    check("rst_async_gnt", 32'(gnt), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_terr", 32'(timeout_err), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rst_then_idle_grant", 32'(gnt), 32'(4'b0010));
    check("rst_then_idle_code", 32'(gnt_code), 32'(2'b10));
    done = 1'b1;
    tick(1);
    done = 1'b0;
    req  = 4'b0000;
    tick(2);

    // All requesting; each owner releases after two cycles
    #1 rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!busy && n < 10) begin
        n++;
        tick(1);
      end
      check("all_req_busy", 32'(busy), 32'h1);
`ifdef REQ_ARBITER_RR_EN
      check("all_req_code", 32'(gnt_code), 32'(i % 4));
`else
      check("all_req_code", 32'(gnt_code), 32'h0);
`endif
      tick(1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
    end
    req = 4'b0000;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
